// File: rtl/bsr_pkg.sv
// bsr_pkg: shared types and helpers for the multi-chain boundary-scan register bank.
package bsr_pkg;

   typedef enum logic [1:0] {ACT_NONE, ACT_CAPTURE, ACT_SHIFT, ACT_UPDATE} act_e;

   // Counter width: enough to hold WIDTH+1 shifts before saturating.
   function automatic int cnt_width(input int width);
      return $clog2(width + 2);
   endfunction

   function automatic logic onehot(input logic [63:0] v);
      return (v != '0) && ((v & (v - 64'd1)) == '0);
   endfunction

endpackage

// File: rtl/bsr_chain.sv
// bsr_chain: one WIDTH-bit boundary-scan shift/update register pair with output select.
module bsr_chain
   import bsr_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             iTCK,
   input  logic             iTRST_n,
   input  act_e             act_i,
   input  logic             tdi_i,
   input  logic             ctrl_en_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             sr0_o
);

   logic [WIDTH-1:0] sr_q, sr_d, ur_q, ur_d;

   always_comb begin
      sr_d = act_i == ACT_CAPTURE ? data_i :
             act_i == ACT_SHIFT   ? {tdi_i, sr_q[WIDTH-1:1]} : sr_q;
      ur_d = act_i == ACT_UPDATE  ? sr_q : ur_q;
   end

   always_ff @(posedge iTCK or negedge iTRST_n) begin
      if (!iTRST_n) begin
         sr_q <= '0;
         ur_q <= '0;
      end else begin
         sr_q <= sr_d;
         ur_q <= ur_d;
      end
   end

   assign data_o = ctrl_en_i ? ur_q : data_i;
   assign sr0_o  = sr_q[0];

endmodule

// File: rtl/bsr_multichain.sv
// bsr_multichain: NCHAN-chain boundary-scan bank with bypass, sticky select error and
// shift-count telemetry (counter present only when BSR_SHIFT_CNT_EN is defined).
module bsr_multichain
   import bsr_pkg::*;
#(
   parameter int               NCHAN     = 4,
   parameter int               WIDTH     = 32,
   parameter logic [NCHAN-1:0] CTRL_MASK = {NCHAN{1'b1}},
   localparam int              CW        = cnt_width(WIDTH)
) (
   input  logic                   iTCK,
   input  logic                   iTRST_n,
   input  logic [NCHAN-1:0]       iSel,
   input  logic                   iShiftDR,
   input  logic                   iCaptureDR,
   input  logic                   iUpdateDR,
   input  logic                   iMode,
   input  logic                   iTDI,
   output logic                   oTDO,
   input  logic [NCHAN*WIDTH-1:0] iData,
   output logic [NCHAN*WIDTH-1:0] oData,
   output logic                   oSelErr,
   output logic [CW-1:0]          oShiftCnt
);

   localparam int SW = NCHAN > 1 ? $clog2(NCHAN) : 1;

   logic             valid;
   logic [SW-1:0]    vsel;
   logic [NCHAN-1:0] sr0;
   act_e             act;
   logic             byp_q, byp_d, err_q, err_d;

   assign valid = onehot(64'(iSel));
   assign act   = iCaptureDR ? ACT_CAPTURE :
                  iShiftDR   ? ACT_SHIFT   :
                  iUpdateDR  ? ACT_UPDATE  : ACT_NONE;

   always_comb begin
      vsel = '0;
      for (int i = 0; i < NCHAN; i++)
         if (iSel[i]) vsel = SW'(i);
   end

   genvar c;
   generate
      for (c = 0; c < NCHAN; c++) begin : g_chain
         bsr_chain #(.WIDTH(WIDTH)) u_chain (
            .iTCK      (iTCK),
            .iTRST_n   (iTRST_n),
            .act_i     ((valid && iSel[c]) ? act : ACT_NONE),
            .tdi_i     (iTDI),
            .ctrl_en_i (iMode & CTRL_MASK[c]),
            .data_i    (iData[c*WIDTH +: WIDTH]),
            .data_o    (oData[c*WIDTH +: WIDTH]),
            .sr0_o     (sr0[c])
         );
      end
   endgenerate

   // The bypass bit and error flag only react while the select is invalid,
   // except that a valid capture clears the error.
   always_comb begin
      byp_d = !valid && act == ACT_CAPTURE ? 1'b0 :
              !valid && act == ACT_SHIFT   ? iTDI : byp_q;
      err_d = valid && act == ACT_CAPTURE  ? 1'b0 :
              !valid && act == ACT_SHIFT   ? 1'b1 : err_q;
   end

   always_ff @(posedge iTCK or negedge iTRST_n) begin
      if (!iTRST_n) begin
         byp_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         byp_q <= byp_d;
         err_q <= err_d;
      end
   end

   assign oTDO    = valid ? sr0[vsel] : byp_q;
   assign oSelErr = err_q;

`ifdef BSR_SHIFT_CNT_EN
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = act == ACT_CAPTURE                  ? '0 :
              act == ACT_SHIFT && cnt_q != '1     ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge iTCK or negedge iTRST_n) begin
      if (!iTRST_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign oShiftCnt = cnt_q;
`else
   assign oShiftCnt = '0;
`endif

endmodule

// File: tb/tb_bsr_multichain.sv
// tb_bsr_multichain: directed self-checking bench for bsr_multichain.
module tb_bsr_multichain;

`ifdef BSR_SHIFT_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic         tck = 1'b0, trst_n = 1'b0;
   logic [3:0]   sel = '0;
   logic         sdr = 0, cdr = 0, udr = 0, mode = 0, tdi = 0;
   logic         tdo, selerr;
   logic [127:0] din = '0, dout;
   logic [5:0]   cnt;

   logic [1:0]   sel8 = '0;
   logic         sdr8 = 0, cdr8 = 0, tdo8, err8;
   logic [15:0]  din8 = 16'h5A3C, dout8;
   logic [3:0]   cnt8;

   int vecs = 0, errs = 0;

   always #5 tck = ~tck;

   bsr_multichain #(.NCHAN(4), .WIDTH(32), .CTRL_MASK(4'b0111)) u_dut (
      .iTCK(tck), .iTRST_n(trst_n), .iSel(sel), .iShiftDR(sdr), .iCaptureDR(cdr),
      .iUpdateDR(udr), .iMode(mode), .iTDI(tdi), .oTDO(tdo), .iData(din), .oData(dout),
      .oSelErr(selerr), .oShiftCnt(cnt)
   );

   bsr_multichain #(.NCHAN(2), .WIDTH(8), .CTRL_MASK(2'b11)) u_dut8 (
      .iTCK(tck), .iTRST_n(trst_n), .iSel(sel8), .iShiftDR(sdr8), .iCaptureDR(cdr8),
      .iUpdateDR(1'b0), .iMode(1'b0), .iTDI(1'b1), .oTDO(tdo8), .iData(din8), .oData(dout8),
      .oSelErr(err8), .oShiftCnt(cnt8)
   );

   task automatic tick;
      @(posedge tck);
      @(negedge tck);
   endtask

   task automatic shift_word(input logic [31:0] v);
      for (int i = 0; i < 32; i++) begin
         tdi = v[i];
         sdr = 1;
         tick();
      end
      sdr = 0;
      tdi = 0;
   endtask

   task automatic test_capture_shift;
      logic [31:0] exp;
      exp = 32'hA5A5_0F0F;
      din[63:32] = exp;
      sel = 4'b0010;
      cdr = 1;
      tick();
      cdr = 0;
      for (int i = 0; i < 32; i++) begin
         vecs++;
         if (tdo !== exp[i]) begin
            errs++;
            $display("FAIL shiftout bit %0d: got %b expected %b", i, tdo, exp[i]);
         end
         tdi = 0;
         sdr = 1;
         tick();
      end
      sdr = 0;
      vecs++;
      if (cnt !== (CNT_EN ? 6'd32 : 6'd0)) begin
         errs++;
         $display("FAIL shiftcnt32: got %0d expected %0d", cnt, CNT_EN ? 32 : 0);
      end
      vecs++;
      if (tdo !== 1'b0) begin
         errs++;
         $display("FAIL shiftout drained: got %b expected 0", tdo);
      end
   endtask

   task automatic test_shift_update;
      sel = 4'b0001;
      mode = 1;
      din[31:0] = 32'h1357_9BDF;
      shift_word(32'hDEAD_BEEF);
      vecs++;
      if (dout[31:0] !== 32'h0) begin
         errs++;
         $display("FAIL pre-update: got %h expected 00000000", dout[31:0]);
      end
      udr = 1;
      tick();
      udr = 0;
      vecs++;
      if (dout[31:0] !== 32'hDEAD_BEEF) begin
         errs++;
         $display("FAIL update: got %h expected deadbeef", dout[31:0]);
      end
      vecs++;
      if (dout[63:32] !== 32'h0) begin
         errs++;
         $display("FAIL chain1 untouched: got %h expected 00000000", dout[63:32]);
      end
      mode = 0;
      #1;
      vecs++;
      if (dout[31:0] !== 32'h1357_9BDF) begin
         errs++;
         $display("FAIL transparent: got %h expected 13579bdf", dout[31:0]);
      end
   endtask

   task automatic test_reset;
      mode = 1;
      din[127:96] = 32'hCAFE_F00D;
      sel = 4'b0010;
      din[63:32] = 32'hFFFF_FFFF;
      cdr = 1;
      tick();
      cdr = 0;
      tdi = 1;
      sdr = 1;
      tick();
      tick();
      trst_n = 0;
      #1;
      vecs++;
      if (dout[95:0] !== 96'h0) begin
         errs++;
         $display("FAIL reset odata: got %h expected 0", dout[95:0]);
      end
      vecs++;
      if (dout[127:96] !== 32'hCAFE_F00D) begin
         errs++;
         $display("FAIL reset observe-only: got %h expected cafef00d", dout[127:96]);
      end
      vecs++;
      if (tdo !== 1'b0 || cnt !== 6'd0 || selerr !== 1'b0) begin
         errs++;
         $display("FAIL reset tdo/cnt/err: got %b/%0d/%b expected 0/0/0", tdo, cnt, selerr);
      end
      sdr = 0;
      tdi = 0;
      tick();
      trst_n = 1;
      tick();
   endtask

   task automatic test_observe_only;
      sel = 4'b1000;
      mode = 1;
      shift_word(32'h1234_5678);
      vecs++;
      if (tdo !== 1'b0) begin
         errs++;
         $display("FAIL chain3 tdo: got %b expected 0", tdo);
      end
      udr = 1;
      tick();
      udr = 0;
      vecs++;
      if (dout[127:96] !== 32'hCAFE_F00D) begin
         errs++;
         $display("FAIL observe-only: got %h expected cafef00d", dout[127:96]);
      end
      mode = 0;
   endtask

   task automatic test_bypass_error;
      logic [2:0] pat;
      pat = 3'b101;
      din[95:64] = 32'h0000_0003;
      sel = 4'b0100;
      cdr = 1;
      tick();
      cdr = 0;
      sel = 4'b0110;
      #1;
      vecs++;
      if (tdo !== 1'b0 || selerr !== 1'b0) begin
         errs++;
         $display("FAIL bypass entry tdo/err: got %b/%b expected 0/0", tdo, selerr);
      end
      for (int i = 0; i < 3; i++) begin
         tdi = pat[i];
         sdr = 1;
         tick();
         vecs++;
         if (tdo !== pat[i]) begin
            errs++;
            $display("FAIL bypass bit %0d: got %b expected %b", i, tdo, pat[i]);
         end
      end
      sdr = 0;
      tdi = 0;
      vecs++;
      if (selerr !== 1'b1 || cnt !== (CNT_EN ? 6'd3 : 6'd0)) begin
         errs++;
         $display("FAIL selerr/cnt: got %b/%0d expected 1/%0d", selerr, cnt, CNT_EN ? 3 : 0);
      end
      sel = 4'b0100;
      #1;
      vecs++;
      if (tdo !== 1'b1) begin
         errs++;
         $display("FAIL chain2 unchanged: got %b expected 1", tdo);
      end
      // Simultaneous capture and shift: capture wins.
      din[95:64] = 32'h0000_0002;
      cdr = 1;
      sdr = 1;
      tdi = 1;
      tick();
      cdr = 0;
      sdr = 0;
      tdi = 0;
      vecs++;
      if (selerr !== 1'b0 || tdo !== 1'b0 || cnt !== 6'd0) begin
         errs++;
         $display("FAIL capture clears err/wins: got %b/%b/%0d expected 0/0/0", selerr, tdo, cnt);
      end
      sdr = 1;
      tick();
      sdr = 0;
      vecs++;
      if (tdo !== 1'b1) begin
         errs++;
         $display("FAIL capture data bit1: got %b expected 1", tdo);
      end
   endtask

   task automatic test_counter_saturation;
      sel = 4'b0001;
      cdr = 1;
      sel8 = 2'b01;
      cdr8 = 1;
      tick();
      cdr = 0;
      cdr8 = 0;
      for (int i = 0; i < 40; i++) begin
         sdr = 1;
         sdr8 = i < 20;
         tick();
      end
      sdr = 0;
      sdr8 = 0;
      vecs++;
      if (cnt !== (CNT_EN ? 6'd40 : 6'd0)) begin
         errs++;
         $display("FAIL cnt40: got %0d expected %0d", cnt, CNT_EN ? 40 : 0);
      end
      vecs++;
      if (cnt8 !== (CNT_EN ? 4'd15 : 4'd0)) begin
         errs++;
         $display("FAIL cnt8 saturate: got %0d expected %0d", cnt8, CNT_EN ? 15 : 0);
      end
      vecs++;
      if (tdo8 !== 1'b1 || err8 !== 1'b0) begin
         errs++;
         $display("FAIL dut8 tdo/err: got %b/%b expected 1/0", tdo8, err8);
      end
   endtask

   task automatic test_initial_reset;
      #1;
      vecs++;
      if (tdo !== 1'b0 || selerr !== 1'b0 || cnt !== 6'd0 || dout !== din) begin
         errs++;
         $display("FAIL initial reset: got tdo=%b err=%b cnt=%0d", tdo, selerr, cnt);
      end
      @(negedge tck);
      trst_n = 1;
      tick();
   endtask

   initial begin
      test_initial_reset();
      test_capture_shift();
      test_shift_update();
      test_reset();
      test_observe_only();
      test_bypass_error();
      test_counter_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
